// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - two-requester arbiter sharing one LEN-bit adder behind a one-entry result slot
module adder_arbiter #(
    parameter int LEN = 32
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_req0_valid,
    input  logic [LEN-1:0] i_req0_a,
    input  logic [LEN-1:0] i_req0_b,
    output logic           o_req0_ready,
    input  logic           i_req1_valid,
    input  logic [LEN-1:0] i_req1_a,
    input  logic [LEN-1:0] i_req1_b,
    output logic           o_req1_ready,
    output logic           o_valid,
    output logic [LEN-1:0] o_result,
    output logic           o_carry,
    output logic           o_id,
    input  logic           i_ready
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic           r_prio;
    logic [LEN-1:0] r_result;
    logic           r_carry;
    logic           r_id;

    logic           w_slot_free;
    logic           w_acc0;
    logic           w_acc1;
    logic           w_accept;
    logic [LEN-1:0] w_op_a;
    logic [LEN-1:0] w_op_b;
    logic [LEN:0]   w_sum;

    // Ready is a pure function of slot occupancy, priority and the other side's valid.
    assign w_slot_free  = !i_reset && ((r_state == S_EMPTY) || i_ready);
    assign o_req0_ready = w_slot_free && (!i_req1_valid || !r_prio);
    assign o_req1_ready = w_slot_free && (!i_req0_valid ||  r_prio);
    assign w_acc0       = o_req0_ready && i_req0_valid;
    assign w_acc1       = o_req1_ready && i_req1_valid;
    assign w_accept     = w_acc0 || w_acc1;

    // The single adder sees whichever requester won this cycle.
    assign w_op_a = w_acc1 ? i_req1_a : i_req0_a;
    assign w_op_b = w_acc1 ? i_req1_b : i_req0_b;
    assign w_sum  = {1'b0, w_op_a} + {1'b0, w_op_b};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_next = S_FULL;
            S_FULL:  if (i_ready && !w_accept) w_state_next = S_EMPTY;
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_EMPTY;
            r_prio   <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_id     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_result <= w_sum[LEN-1:0];
                r_carry  <= w_sum[LEN];
                r_id     <= w_acc1;
                r_prio   <= !w_acc1;
            end
        end
    end

    assign o_valid  = (r_state == S_FULL);
    assign o_result = r_result;
    assign o_carry  = r_carry;
    assign o_id     = r_id;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - randomized and directed bench for adder_arbiter against a transaction-level model
module tb_adder_arbiter;

    localparam int LEN = 32;

    logic           i_clk = 1'b0;
    logic           i_reset = 1'b1;
    logic           i_req0_valid = 1'b0;
    logic [LEN-1:0] i_req0_a = '0;
    logic [LEN-1:0] i_req0_b = '0;
    logic           o_req0_ready;
    logic           i_req1_valid = 1'b0;
    logic [LEN-1:0] i_req1_a = '0;
    logic [LEN-1:0] i_req1_b = '0;
    logic           o_req1_ready;
    logic           o_valid;
    logic [LEN-1:0] o_result;
    logic           o_carry;
    logic           o_id;
    logic           i_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: slot occupancy, priority and the last produced result.
    bit             m_full;
    bit             m_prio;
    logic [LEN-1:0] m_result;
    bit             m_carry;
    bit             m_id;

    adder_arbiter #(.LEN(LEN)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req0_valid (i_req0_valid),
        .i_req0_a     (i_req0_a),
        .i_req0_b     (i_req0_b),
        .o_req0_ready (o_req0_ready),
        .i_req1_valid (i_req1_valid),
        .i_req1_a     (i_req1_a),
        .i_req1_b     (i_req1_b),
        .o_req1_ready (o_req1_ready),
        .o_valid      (o_valid),
        .o_result     (o_result),
        .o_carry      (o_carry),
        .o_id         (o_id),
        .i_ready      (i_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full = 0; m_prio = 0; m_result = '0; m_carry = 0; m_id = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"},  o_valid,  m_full);
        check({tag, ".result"}, o_result, m_result);
        check({tag, ".carry"},  o_carry,  m_carry);
        check({tag, ".id"},     o_id,     m_id);
    endtask

    // One clock cycle: called just after a falling edge, returns just after the next falling edge.
    task automatic cycle(input string tag, input bit v0, input logic [LEN-1:0] a0, input logic [LEN-1:0] b0,
                         input bit v1, input logic [LEN-1:0] a1, input logic [LEN-1:0] b1, input bit rdy);
        bit free, r0, r1;
        longint unsigned sum;
        i_req0_valid = v0; i_req0_a = a0; i_req0_b = b0;
        i_req1_valid = v1; i_req1_a = a1; i_req1_b = b1;
        i_ready = rdy;
        #1;
        free = !m_full || rdy;
        r0 = free && (!v1 || !m_prio);
        r1 = free && (!v0 || m_prio);
        check({tag, ".ready0"}, o_req0_ready, r0);
        check({tag, ".ready1"}, o_req1_ready, r1);
        @(posedge i_clk);
        if (v0 && r0) begin
            sum = longint'(a0) + longint'(b0);
            m_result = sum[LEN-1:0]; m_carry = sum[LEN]; m_id = 0; m_prio = 1; m_full = 1;
        end else if (v1 && r1) begin
            sum = longint'(a1) + longint'(b1);
            m_result = sum[LEN-1:0]; m_carry = sum[LEN]; m_id = 1; m_prio = 0; m_full = 1;
        end else if (rdy) begin
            m_full = 0;
        end
        #1;
        check_outputs(tag);
        @(negedge i_clk);
    endtask

    initial begin
        logic [LEN-1:0] ra0, rb0, ra1, rb1;
        model_reset();
        // Reset holds everything quiet even with requests pending and the clock running.
        i_req0_valid = 1; i_req1_valid = 1; i_ready = 1;
        repeat (2) @(posedge i_clk);
        #1;
        check_outputs("reset");
        check("reset.ready0", o_req0_ready, 1'b0);
        check("reset.ready1", o_req1_ready, 1'b0);
        @(negedge i_clk);
        i_reset = 0;

        cycle("single", 1, 32'd5, 32'd7, 0, '0, '0, 1);
        check("single.sum12", o_result, 32'd12);
        cycle("ovf", 0, '0, '0, 1, 32'hFFFF_FFFF, 32'h2, 1);
        check("ovf.wrap", o_result, 32'h1);
        check("ovf.carry", o_carry, 1'b1);
        cycle("drain", 0, '0, '0, 0, '0, '0, 1);

        // Contention: prio is 0 after req1's overflow grant, so 0,1,0,1 follows.
        for (int i = 0; i < 4; i++) begin
            cycle("contend", 1, i, 32'd100, 1, i, 32'd200, 1);
            check("contend.id", o_id, i[0]);
        end

        // Backpressure with both requesters waiting, then zero-bubble reload.
        for (int i = 0; i < 3; i++)
            cycle("bp", 1, 32'd1, 32'd1, 1, 32'd2, 32'd2, 0);
        cycle("bp.release", 1, 32'd1, 32'd1, 1, 32'd2, 32'd2, 1);
        check("bp.nobubble", o_valid, 1'b1);
        cycle("drain2", 0, '0, '0, 0, '0, '0, 1);
        check("drain2.empty", o_valid, 1'b0);

        // Asynchronous reset while the slot is full.
        cycle("prefill", 1, 32'd9, 32'd9, 0, '0, '0, 1);
        #2;
        i_reset = 1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge i_clk);
        i_reset = 0;
        cycle("post_rst.req1", 0, '0, '0, 1, 32'd3, 32'd4, 0);
        cycle("post_rst.drain", 0, '0, '0, 0, '0, '0, 1);
        cycle("post_rst.both", 1, 32'd10, 32'd1, 1, 32'd20, 32'd2, 1);
        check("post_rst.req0_first", o_id, 1'b0);

        for (int i = 0; i < 400; i++) begin
            ra0 = $urandom; rb0 = $urandom; ra1 = $urandom; rb1 = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                ra0 = 32'hFFFF_FFFF; rb1 = 32'hFFFF_FFFF;
            end
            cycle("rand", $urandom_range(0, 1), ra0, rb0, $urandom_range(0, 1), ra1, rb1,
                  $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: LEN, default 32, operand and result width in bits.
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_reset  input  1  reset, asynchronous, active-high.
REQ-004 i_req0_valid  input  1  requester 0 presents an add request.
REQ-005 i_req0_a, i_req0_b  input  LEN each  requester 0 operands.
REQ-006 o_req0_ready  output  1  requester 0 request accepted this cycle when high with i_req0_valid.
REQ-007 i_req1_valid, i_req1_a, i_req1_b, o_req1_ready  same as REQ-004..006, for requester 1.
REQ-008 o_valid  output  1  result slot holds a valid result.
REQ-009 o_result  output  LEN  sum of the accepted operands.
REQ-010 o_carry  output  1  carry-out of that sum.
REQ-011 o_id  output  1  index of the requester that owns the result.
REQ-012 i_ready  input  1  consumer takes the result this cycle when high with o_valid.

Function
REQ-013 The block SHALL contain exactly one LEN-bit adder, shared by both requesters.
REQ-014 Result slot states: EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-015 slot_free SHALL be high when state is EMPTY, or FULL with i_ready=1 in the same cycle.
REQ-016 Priority pointer prio (1 bit) SHALL select the winner when both requesters are valid.
REQ-017 o_req0_ready SHALL equal slot_free AND (NOT i_req1_valid OR prio=0); o_req0_ready SHALL NOT depend on i_req0_valid.
REQ-018 o_req1_ready SHALL equal slot_free AND (NOT i_req0_valid OR prio=1); o_req1_ready SHALL NOT depend on i_req1_valid.
REQ-019 At most one request SHALL be accepted per cycle.
REQ-020 On acceptance from requester N, o_result, o_carry and o_id SHALL be registered at the next edge: {o_carry,o_result} = a+b as a (LEN+1)-bit sum; o_id = N; o_valid = 1.
REQ-021 Latency SHALL be exactly 1 cycle, from accept edge to o_valid high.
REQ-022 After any acceptance from requester N, prio SHALL become NOT N, whether or not the other requester was valid.
REQ-023 With no acceptance, prio SHALL hold its value.
REQ-024 In FULL without i_ready, o_valid, o_result, o_carry and o_id SHALL hold stable; both ready outputs SHALL be 0.
REQ-025 In FULL with i_ready=1 and an acceptance, the slot SHALL reload with the new result with no bubble (o_valid stays 1).
REQ-026 In FULL with i_ready=1 and no acceptance, the state SHALL become EMPTY and o_valid 0; o_result, o_carry and o_id hold their last values.
REQ-027 Throughput SHALL be one result per cycle while the consumer keeps i_ready high.
REQ-028 Operand overflow SHALL wrap modulo 2^LEN in o_result, with the carry reported in o_carry only; no saturation.
REQ-029 Under continuous contention, the two requesters SHALL be granted alternately; neither waits more than one grant.

Reset
REQ-030 While i_reset is high, the block SHALL hold o_valid=0, o_result=0, o_carry=0, o_id=0, prio=0 and state EMPTY, regardless of i_clk.
REQ-031 While i_reset is high, both ready outputs SHALL be 0, and no request is accepted.
REQ-032 Reset asserted with a result pending SHALL discard the result; the first cycle after deassertion behaves as EMPTY with prio=0.

Verification
REQ-033 Single request: req0 a=5, b=7, i_ready=1 -> o_req0_ready=1; next cycle o_valid=1, o_result=12, o_carry=0, o_id=0.
REQ-034 Overflow (LEN=32): req1 a=FFFFFFFF, b=00000002 -> o_result=00000001, o_carry=1, o_id=1.
REQ-035 Contention: both valid every cycle, i_ready=1, after reset -> o_id sequence 0,1,0,1; one result per cycle.
REQ-036 Backpressure: result pending, i_ready=0 for 3 cycles, both requesters valid -> both ready outputs 0; o_result, o_id stable. Then i_ready=1 -> the prio winner is accepted in the same cycle with no bubble.
REQ-037 Drain: FULL, i_ready=1, no requests -> o_valid=0 next cycle; prio unchanged.
REQ-038 Reset mid-operation: i_reset asserted asynchronously while FULL -> o_valid=0 immediately. After release, req1 alone is accepted; a later simultaneous request grants req0 first (prio=0).
